muldiv_iter_unit: RTL and testbench
===================================

Name: muldiv_iter_unit

Overview:
- Multi-cycle RV32M multiply/divide unit; replaces the combinational mul/div path inside the execute-stage ExecutionUnit.
- Sits beside the execute ALU. Execute stalls while in_ready=0 or a result is pending.
- valid/ready handshake on both sides; iterative radix-2 divider; multiplier is iterative or single-cycle by parameter.
- flush input squashes an in-flight op on a taken branch or jump.

Parameters:
- WIDTH, 32: operand and result width; must be even and ≥ 8.
- TAG_W, 5: width of the destination-register tag carried with each op.
- MUL_ITERATIVE, 1: 1 = shift-add multiply (WIDTH cycles); 0 = single registered multiply (1 cycle).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  op request.
- in_ready  out  1  high only in IDLE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  WIDTH  rs1 value.
- op_b  in  WIDTH  rs2 value.
- tag_in  in  TAG_W  rd index.
- flush  in  1  abort current op; discard any pending result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result value.
- tag_out  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; out_valid=0; result=0; tag_out=0; busy=0; in_ready=1 after reset deasserts; all internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- Accept occurs on an edge where in_valid & in_ready & !flush. Latch funct3, tag_in, operand magnitudes, and result sign flags.
- Special cases go IDLE->DONE directly, 1-cycle latency:
  - DIV/DIVU, op_b=0: quotient = all ones.
  - REM/REMU, op_b=0: remainder = op_a.
  - DIV, op_a = most-negative and op_b = -1: quotient = op_a.
  - REM, same operands: remainder = 0.
- Multiply, MUL_ITERATIVE=0: IDLE->DONE; full 2*WIDTH product computed in the accept cycle; out_valid 1 cycle after accept.
- Iterative path: IDLE->CALC. CALC runs exactly WIDTH iterations on an internal counter (0..WIDTH-1), then goes to FIX for one cycle, then to DONE. out_valid rises WIDTH+2 cycles after accept.
- Divide: restoring, unsigned on magnitudes. Signed ops use |op_a| and |op_b|.
- FIX state:
  - DIV: negate quotient if signs differ.
  - REM: negate remainder if dividend negative.
  - MUL/MULH/MULHSU: negate the 2*WIDTH product if operand signs differ. MULHSU treats op_b as unsigned.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH, MULHSU, MULHU: high WIDTH bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- DONE: out_valid=1; result and tag_out held stable until out_ready=1. The edge with out_ready=1 moves to IDLE.
- Back-to-back: in_ready is 0 in DONE, so a new op is accepted no earlier than the cycle after the result handshake.
- flush=1 in any state: next state IDLE, out_valid=0, counter cleared. flush takes priority over accept and over out_ready. If flush and out_ready are high on the same edge in DONE, the result is dropped.
- rst asserted mid-operation: immediate return to reset values. No partial result ever appears.
- in_valid while busy is ignored. The requester must hold the op until in_ready=1.

Decomposition:
- Shared package (muldiv_pkg):
  - funct3 encodings (MD_MUL..MD_REMU).
  - State encoding localparams.
  - Execute-stage opcode/funct7 constant 7'b0000001 (M extension), reused by the decoder to route ops to this unit.
- Sub-module muldiv_special_case (combinational):
  - Detects divide-by-zero and signed overflow.
  - Produces the fast-path result.
  - Keeps the FSM file focused on iteration.

Test Plan:
- DIV op_a=-20 (0xFFFFFFEC), op_b=3 -> result 0xFFFFFFFA (-6), out_valid exactly 34 cycles after accept (WIDTH=32), tag_out=tag_in.
- REMU op_a=7, op_b=0 -> result 7, out_valid 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- MULHSU op_a=0xFFFFFFFF (-1), op_b=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE. MUL 0x7FFFFFFF*2 -> 0xFFFFFFFE. Run with MUL_ITERATIVE=0 and =1; latencies 1 and 34.
- Hold out_ready=0 for 5 cycles in DONE -> result and tag_out stable, in_ready=0, a second in_valid ignored. Then out_ready=1 -> IDLE, and the next op is accepted one cycle later.
- Assert flush at CALC iteration 10 -> out_valid never rises, in_ready=1 the next cycle, and a new DIVU 100/7 returns 14.
- Pull rst low asynchronously mid-CALC -> out_valid=0, busy=0, result=0 immediately without a clock edge. After release, REM -7 % 2 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // funct7 value that marks an OP instruction as M-extension (decoder routing)
    localparam logic [6:0] MD_FUNCT7_MEXT = 7'b0000001;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Divide and remainder ops all have funct3[2] set
    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // Remainder ops are the divide ops with funct3[1] set
    function automatic logic md_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Divide fast path: divide-by-zero and signed overflow produce a result
// without iterating.
module muldiv_special_case
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             is_special,
    output logic [WIDTH-1:0] special_result
);

    logic signed_div_s;
    logic div_zero_s;
    logic overflow_s;

    // Detect the two corner cases and pick their architectural result
    always_comb begin
        signed_div_s = (funct3 == MD_DIV) || (funct3 == MD_REM);
        div_zero_s   = md_is_div(funct3) && (op_b == {WIDTH{1'b0}});
        overflow_s   = signed_div_s
                       && (op_a == {1'b1, {(WIDTH-1){1'b0}}})
                       && (op_b == {WIDTH{1'b1}});
        is_special   = div_zero_s | overflow_s;
        if (div_zero_s) begin
            special_result = md_is_rem(funct3) ? op_a : {WIDTH{1'b1}};
        end else if (overflow_s) begin
            special_result = md_is_rem(funct3) ? {WIDTH{1'b0}} : op_a;
        end else begin
            special_result = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Multi-cycle RV32M multiply/divide unit: restoring radix-2 divider and
// shift-add (or single-cycle) multiplier sharing one 2*WIDTH accumulator.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int TAG_W         = 5,
    parameter int MUL_ITERATIVE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_q, neg_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             sc_special_s;
    logic [WIDTH-1:0] sc_result_s;

    logic             signed_a_s, signed_b_s, neg_a_s, neg_b_s, neg_res_s;
    logic             fast_mul_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s, fast_result_s;
    logic [W2-1:0]    prod_fast_s, prod_fast_fix_s;
    logic [WIDTH:0]   div_r_s, div_diff_s, mul_sum_s;
    logic             div_ge_s;
    logic [W2-1:0]    div_step_s, mul_step_s, prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s, fix_result_s;

    muldiv_special_case #(.WIDTH(WIDTH)) u_special (
        .funct3         (funct3),
        .op_a           (op_a),
        .op_b           (op_b),
        .is_special     (sc_special_s),
        .special_result (sc_result_s)
    );

    // Operand decode at accept: signedness, magnitudes, result sign, fast multiply
    always_comb begin
        signed_a_s = (funct3 == MD_MULH) || (funct3 == MD_MULHSU)
                     || (funct3 == MD_DIV) || (funct3 == MD_REM);
        signed_b_s = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
        neg_a_s    = signed_a_s & op_a[WIDTH-1];
        neg_b_s    = signed_b_s & op_b[WIDTH-1];
        mag_a_s    = neg_a_s ? -op_a : op_a;
        mag_b_s    = neg_b_s ? -op_b : op_b;
        // Remainder takes the dividend's sign; everything else the xor of signs
        neg_res_s  = md_is_rem(funct3) ? neg_a_s : (neg_a_s ^ neg_b_s);
        fast_mul_s = (MUL_ITERATIVE == 0) && !md_is_div(funct3);
        prod_fast_s     = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
        prod_fast_fix_s = neg_res_s ? -prod_fast_s : prod_fast_s;
        if (funct3 == MD_MUL) begin
            fast_result_s = prod_fast_fix_s[WIDTH-1:0];
        end else begin
            fast_result_s = prod_fast_fix_s[W2-1:WIDTH];
        end
    end

    // One iteration of each engine; acc holds {remainder, quotient} or {partial, multiplier}
    always_comb begin
        div_r_s    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_ge_s   = (div_r_s >= {1'b0, opb_q});
        div_diff_s = div_r_s - {1'b0, opb_q};
        if (div_ge_s) begin
            div_step_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {div_r_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        mul_sum_s  = {1'b0, acc_q[W2-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end

    // Sign fix-up and result selection applied in the FIX cycle
    always_comb begin
        prod_fix_s = neg_q ? -acc_q : acc_q;
        quo_fix_s  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_s  = neg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
        case (f3_q)
            MD_MUL:                      fix_result_s = prod_fix_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result_s = prod_fix_s[W2-1:WIDTH];
            MD_DIV, MD_DIVU:             fix_result_s = quo_fix_s;
            MD_REM, MD_REMU:             fix_result_s = rem_fix_s;
            default:                     fix_result_s = quo_fix_s;
        endcase
    end

    // Next-state logic; flush overrides accept and the result handshake
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (sc_special_s || fast_mul_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: latch op at accept, iterate in CALC, finalise in FIX
    always_comb begin
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (flush) begin
            cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        f3_d  = funct3;
                        tag_d = tag_in;
                        neg_d = neg_res_s;
                        cnt_d = CNT_ZERO;
                        acc_d = {{WIDTH{1'b0}}, mag_a_s};
                        opb_d = mag_b_s;
                        if (sc_special_s) begin
                            result_d = sc_result_s;
                        end else if (fast_mul_s) begin
                            result_d = fast_result_s;
                        end else begin
                            result_d = result_q;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_CALC: begin
                    acc_d = md_is_div(f3_q) ? div_step_s : mul_step_s;
                    cnt_d = (cnt_q == CNT_LAST) ? CNT_ZERO : (cnt_q + CNT_ONE);
                end
                ST_FIX:  result_d = fix_result_s;
                ST_DONE: result_d = result_q;
                default: cnt_d = CNT_ZERO;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            f3_q     <= 3'b000;
            tag_q    <= {TAG_W{1'b0}};
            neg_q    <= 1'b0;
            acc_q    <= {W2{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        tag_out   = tag_q;
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: iterative-multiply instance plus a
// single-cycle-multiply instance, scoreboard of expected results.
module tb_muldiv_iter_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                           F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                           F_REM = 3'b110, F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_valid_c = 1'b0;
    logic        out_ready = 1'b0, out_ready_c = 1'b0;
    logic        flush = 1'b0, flush_c = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'd0, op_b = 32'd0;
    logic [4:0]  tag_in = 5'd0;
    logic        in_ready, out_valid, busy;
    logic        in_ready_c, out_valid_c, busy_c;
    logic [31:0] result, result_c;
    logic [4:0]  tag_out, tag_out_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    muldiv_iter_unit #(.WIDTH(32), .TAG_W(5), .MUL_ITERATIVE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out), .busy(busy)
    );

    muldiv_iter_unit #(.WIDTH(32), .TAG_W(5), .MUL_ITERATIVE(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
        .flush(flush_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .result(result_c), .tag_out(tag_out_c), .busy(busy_c)
    );

    // Independent RV32M reference built on 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            F_MUL:    begin p = ua * ub;               return p[31:0];  end
            F_MULH:   begin p = 64'(sa * sb);          return p[63:32]; end
            F_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            F_MULHU:  begin p = ua * ub;               return p[63:32]; end
            F_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            F_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F_REM:    return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default:  return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input bit sel, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 32'd0)) return 1;
        if (((f3 == F_DIV) || (f3 == F_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
            return 1;
        if (sel && !f3[2]) return 1;
        return 34;
    endfunction

    task automatic push_exp(input logic [31:0] r, input logic [4:0] t, input int l);
        exp_t e;
        e.res = r; e.tag = t; e.lat = l;
        sb_q.push_back(e);
    endtask

    // Drive one op on the selected instance, wait for its result, optionally ack it
    task automatic run_op(input bit sel, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg, input bit ack,
                          output logic [31:0] res, output logic [4:0] tgo,
                          output int lat, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; tag_in = tg;
        if (sel) in_valid_c = 1'b1; else in_valid = 1'b1;
        n = 0;
        while (!(sel ? in_ready_c : in_ready) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid_c = 1'b0;
        lat = 1;
        while (!(sel ? out_valid_c : out_valid) && (lat < 200)) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!(sel ? out_valid_c : out_valid)) ok = 1'b0;
        res = sel ? result_c : result;
        tgo = sel ? tag_out_c : tag_out;
        if (ack) begin
            if (sel) out_ready_c = 1'b1; else out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0; out_ready_c = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_tests += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
        if (tag_out !== 5'd0) begin n_fail++; $display("FAIL reset_tag got %h exp 0", tag_out); end
    endtask

    // Table-driven ops on one instance, expectations from the scoreboard
    task automatic test_table(input string name, input bit sel, input int cnt,
                              input logic [2:0] f3s[8], input logic [31:0] as[8],
                              input logic [31:0] bs[8], input logic [31:0] exps[8]);
        logic [31:0] r; logic [4:0] t; int l; bit ok; exp_t e;
        for (int i = 0; i < cnt; i++) begin
            push_exp(exps[i], 5'(i + 3), ref_lat(sel, f3s[i], as[i], bs[i]));
            run_op(sel, f3s[i], as[i], bs[i], 5'(i + 3), 1'b1, r, t, l, ok);
            e = sb_q.pop_front();
            n_tests += 4;
            if (!ok) begin n_fail++; $display("FAIL %s_%0d_timeout got lat %0d exp %0d", name, i, l, e.lat); end
            if (r !== e.res) begin n_fail++; $display("FAIL %s_%0d_result got %h exp %h", name, i, r, e.res); end
            if (t !== e.tag) begin n_fail++; $display("FAIL %s_%0d_tag got %h exp %h", name, i, t, e.tag); end
            if (l !== e.lat) begin n_fail++; $display("FAIL %s_%0d_latency got %0d exp %0d", name, i, l, e.lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f[8] = '{F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM, F_DIVU, F_REMU};
        logic [31:0] a[8] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
                              32'd7, 32'd7, 32'd100, 32'd100};
        logic [31:0] b[8] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'd7, 32'd7};
        logic [31:0] x[8] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h5555_554E, 32'd2,
                              32'hFFFF_FFFD, 32'd1, 32'd14, 32'd2};
        test_table("div", 1'b0, 8, f, a, b, x);
    endtask

    task automatic test_special();
        logic [2:0]  f[8] = '{F_REMU, F_DIV, F_REM, F_DIVU, F_REM, F_DIV, F_DIV, F_DIV};
        logic [31:0] a[8] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7,
                              32'd9, 32'd0, 32'd0};
        logic [31:0] b[8] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0};
        logic [31:0] x[8] = '{32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        test_table("special", 1'b0, 6, f, a, b, x);
    endtask

    task automatic test_mul(input bit sel);
        logic [2:0]  f[8] = '{F_MULHSU, F_MULHU, F_MUL, F_MULH, F_MULH, F_MUL, F_MULHSU, F_MULH};
        logic [31:0] a[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'd6};
        logic [31:0] b[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'd5,
                              32'd5, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] x[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h4000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd1, 32'd0};
        test_table(sel ? "mul_single" : "mul_iter", sel, 8, f, a, b, x);
    endtask

    task automatic test_random();
        logic [2:0]  f[8];
        logic [31:0] a[8], b[8], x[8];
        for (int i = 0; i < 8; i++) begin
            f[i] = 3'(i);
            a[i] = $urandom;
            b[i] = $urandom;
            x[i] = ref_op(f[i], a[i], b[i]);
        end
        test_table("rand_iter", 1'b0, 8, f, a, b, x);
        test_table("rand_single", 1'b1, 8, f, a, b, x);
    endtask

    // Result held in DONE with out_ready low; next op accepted one cycle after handshake
    task automatic test_back_to_back();
        logic [31:0] r; logic [4:0] t; int l; bit ok; exp_t e;
        push_exp(32'd14, 5'd3, 34);
        run_op(1'b0, F_DIVU, 32'd100, 32'd7, 5'd3, 1'b0, r, t, l, ok);
        e = sb_q.pop_front();
        n_tests += 3;
        if (!ok) begin n_fail++; $display("FAIL hold_timeout got lat %0d exp %0d", l, e.lat); end
        if (r !== e.res) begin n_fail++; $display("FAIL hold_result got %h exp %h", r, e.res); end
        if (t !== e.tag) begin n_fail++; $display("FAIL hold_tag got %h exp %h", t, e.tag); end
        @(negedge clk);
        funct3 = F_MUL; op_a = 32'd6; op_b = 32'd7; tag_in = 5'd9; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_tests += 4;
            if (result !== 32'd14) begin n_fail++; $display("FAIL hold_stable_result got %h exp %h", result, 32'd14); end
            if (tag_out !== 5'd3) begin n_fail++; $display("FAIL hold_stable_tag got %h exp 3", tag_out); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready got %b exp 0", in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid got %b exp 1", out_valid); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_tests += 3;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_in_ready got %b exp 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_out_valid got %b exp 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
        push_exp(32'd42, 5'd9, 34);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_tests += 1;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b exp 1", busy); end
        l = 1;
        while (!out_valid && (l < 200)) begin
            @(posedge clk);
            #1;
            l++;
        end
        e = sb_q.pop_front();
        n_tests += 3;
        if (result !== e.res) begin n_fail++; $display("FAIL b2b_result got %h exp %h", result, e.res); end
        if (tag_out !== e.tag) begin n_fail++; $display("FAIL b2b_tag got %h exp %h", tag_out, e.tag); end
        if (l !== e.lat) begin n_fail++; $display("FAIL b2b_latency got %0d exp %0d", l, e.lat); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Flush at CALC iteration 10 squashes the op; a following DIVU completes normally
    task automatic test_flush();
        logic [31:0] r; logic [4:0] t; int l; bit ok; bit seen; exp_t e;
        @(negedge clk);
        funct3 = F_DIV; op_a = 32'd1000; op_b = 32'd3; tag_in = 5'd12; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_tests += 3;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b exp 0", busy); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_tests += 1;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result got %b exp 0", seen); end
        push_exp(32'd14, 5'd4, 34);
        run_op(1'b0, F_DIVU, 32'd100, 32'd7, 5'd4, 1'b1, r, t, l, ok);
        e = sb_q.pop_front();
        n_tests += 3;
        if (r !== e.res || !ok) begin n_fail++; $display("FAIL flush_next_result got %h exp %h", r, e.res); end
        if (t !== e.tag) begin n_fail++; $display("FAIL flush_next_tag got %h exp %h", t, e.tag); end
        if (l !== e.lat) begin n_fail++; $display("FAIL flush_next_latency got %0d exp %0d", l, e.lat); end
    endtask

    // Asynchronous reset mid-CALC clears outputs without a clock edge
    task automatic test_async_reset();
        logic [31:0] r; logic [4:0] t; int l; bit ok; exp_t e;
        @(negedge clk);
        funct3 = F_DIVU; op_a = 32'd1000; op_b = 32'd3; tag_in = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests += 1;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got %b exp 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        n_tests += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b exp 0", out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy); end
        if (result !== 32'd0) begin n_fail++; $display("FAIL arst_result got %h exp 0", result); end
        if (tag_out !== 5'd0) begin n_fail++; $display("FAIL arst_tag got %h exp 0", tag_out); end
        @(negedge clk);
        rst = 1'b1;
        push_exp(32'hFFFF_FFFF, 5'd6, 34);
        run_op(1'b0, F_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, r, t, l, ok);
        e = sb_q.pop_front();
        n_tests += 3;
        if (r !== e.res || !ok) begin n_fail++; $display("FAIL arst_rem_result got %h exp %h", r, e.res); end
        if (t !== e.tag) begin n_fail++; $display("FAIL arst_rem_tag got %h exp %h", t, e.tag); end
        if (l !== e.lat) begin n_fail++; $display("FAIL arst_rem_latency got %0d exp %0d", l, e.lat); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_div();
        test_special();
        test_mul(1'b0);
        test_mul(1'b1);
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
